fetch_buffer: RTL

Instruction fetch stage directly upstream of the `Decode` block. Issues 8-byte-aligned memory reads from a running fetch PC, splits each 64-bit response into two 32-bit instructions, and queues (address, instruction) pairs in a small FIFO. `Decode` consumes the FIFO head through a valid/ready handshake. A redirect, from a branch or jump resolved downstream, flushes the queue, discards any in-flight response and restarts fetch at the new PC.

---
 rtl/fetch_buffer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Instruction fetch stage. Issues 8-byte-aligned reads from a
//            running fetch PC, splits each 64-bit response into two 32-bit
//            instructions and queues (addr, instr) pairs for Decode.
//            A redirect flushes the queue, drops any in-flight response and
//            restarts fetch at the new PC.
// Options  : define FETCH_STALL_CNT_EN to add the stall_cycles counter port.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,
    output logic        out_valid,
    output logic [63:0] out_addr,
    output logic [31:0] out_instr,
    input  logic        out_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int unsigned     c_PTR_W = $clog2(DEPTH);
    localparam int unsigned     c_CNT_W = c_PTR_W + 1;
    // Two free slots are needed before a request may be issued
    localparam logic [c_CNT_W-1:0] c_ROOM = c_CNT_W'(DEPTH - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t               r_state;
    logic [63:0]          r_fetch_pc;
    logic [63:0]          r_req_addr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [63:0]          r_addr_mem  [DEPTH];
    logic [31:0]          r_instr_mem [DEPTH];

    logic                 w_pop;
    logic                 w_push;
    logic                 w_push_two;
    logic [c_CNT_W-1:0]   w_push_n;
    logic [c_PTR_W-1:0]   w_wr_ptr1;
    logic [63:0]          w_req_addr4;
    logic [63:0]          w_wa0;
    logic [31:0]          w_wd0;
    logic                 w_unused;

    // Redirect overrides both push and pop in its cycle
    assign w_pop       = (r_count != '0) && out_ready && !redirect_valid;
    assign w_push      = (r_state == S_WAIT) && mem_resp_valid && !redirect_valid;
    // A fetch PC in the upper half of the block only wants the upper word
    assign w_push_two  = w_push && !r_fetch_pc[2];
    assign w_push_n    = !w_push ? c_CNT_W'(0) : (w_push_two ? c_CNT_W'(2) : c_CNT_W'(1));
    assign w_wr_ptr1   = r_wr_ptr + c_PTR_W'(1);
    assign w_req_addr4 = r_req_addr + 64'd4;
    assign w_wa0       = r_fetch_pc[2] ? w_req_addr4 : r_req_addr;
    assign w_wd0       = r_fetch_pc[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];

    assign mem_req_valid = (r_state == S_REQ);
    assign mem_req_addr  = r_req_addr;
    assign out_valid     = (r_count != '0);
    assign out_addr      = r_addr_mem[r_rd_ptr];
    assign out_instr     = r_instr_mem[r_rd_ptr];

    // Low PC bits are always zero inside the block
    assign w_unused = ^{redirect_pc[1:0], r_fetch_pc[1:0]};

    // Fetch control FSM: owns fetch PC, request address and state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= 64'h0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[63:2], 2'b00};
            unique case (r_state)
                S_IDLE:  r_state <= S_IDLE;
                // A request accepted this cycle still owes us a response
                S_REQ:   r_state <= mem_req_ready  ? S_DROP : S_IDLE;
                S_WAIT:  r_state <= mem_resp_valid ? S_IDLE : S_DROP;
                // A response arriving now retires the outstanding request
                S_DROP:  r_state <= mem_resp_valid ? S_IDLE : S_DROP;
                default: r_state <= S_IDLE;
            endcase
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_count <= c_ROOM) begin
                        r_req_addr <= {r_fetch_pc[63:3], 3'b000};
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        r_fetch_pc <= r_req_addr + 64'd8;
                        r_state    <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (mem_resp_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Queue pointers and occupancy; redirect flushes everything
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_push_two ? (r_wr_ptr + c_PTR_W'(2)) : w_wr_ptr1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + w_push_n - c_CNT_W'(w_pop);
        end
    end

    // Queue storage: first word lands at wr_ptr, second (if any) at wr_ptr+1
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        localparam logic [c_PTR_W-1:0] c_IDX = c_PTR_W'(gi);

        // One storage slot
        always_ff @(posedge clk) begin
            if (reset) begin
                r_addr_mem[gi]  <= 64'h0;
                r_instr_mem[gi] <= 32'h0;
            end else if (w_push && (r_wr_ptr == c_IDX)) begin
                r_addr_mem[gi]  <= w_wa0;
                r_instr_mem[gi] <= w_wd0;
            end else if (w_push_two && (w_wr_ptr1 == c_IDX)) begin
                r_addr_mem[gi]  <= w_req_addr4;
                r_instr_mem[gi] <= mem_resp_data[63:32];
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    // Saturating count of cycles Decode wanted an instruction and had none
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 32'h0;
        end else if (out_ready && !out_valid && !redirect_valid &&
                     (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire
